// File: rtl/cpu_pkg.sv
// ============================================================================
// Module  : cpu_pkg
// Purpose : Shared definitions for the single-cycle MIPS32 subset core.
//           Holds the word width, the opcode and funct constants, the ALU
//           operation encoding and a sign-extension helper.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_NOR = 3'd4,
    ALU_SLT = 3'd5
  } alu_op_e;

  function automatic word_t sext16(input logic [15:0] imm);
    return {{(WORD_W-16){imm[15]}}, imm};
  endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_alu.sv
// ============================================================================
// Module  : cpu_alu
// Purpose : 32-bit combinational ALU: add, sub, and, or, nor, signed slt.
//           All arithmetic wraps. The zero flag drives the beq decision.
// Ports   : a, b     - operands
//           op       - operation select (alu_op_e)
//           result   - operation result
//           zero     - high when result is all zeros
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_alu
  import cpu_pkg::*;
(
  input  word_t   a,
  input  word_t   b,
  input  alu_op_e op,
  output word_t   result,
  output logic    zero
);

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_NOR: result = ~(a | b);
      ALU_SLT: result = ($signed(a) < $signed(b)) ? word_t'(1) : word_t'(0);
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

`default_nettype wire

// File: rtl/cpu_dmem.sv
// ============================================================================
// Module  : cpu_dmem
// Purpose : Data memory, DEPTH 32-bit words addressed by byte address.
//           Byte-offset bits [1:0] are ignored. Out-of-range loads return 0
//           and out-of-range stores are dropped. Combinational read,
//           synchronous write; never reset.
// Ports   : clock  - write clock
//           we     - store enable
//           addr   - byte address
//           wdata  - store data
//           rdata  - load data
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_dmem
  import cpu_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic  clock,
  input  logic  we,
  input  word_t addr,
  input  word_t wdata,
  output word_t rdata
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  word_t data [0:DEPTH-1];

  logic [29:0] word_idx;
  logic        in_range;
  logic        unused_byte_offset;

  assign word_idx           = addr[31:2];
  assign in_range           = (word_idx < 30'(DEPTH));
  assign unused_byte_offset = ^addr[1:0];

  always_ff @(posedge clock) begin
    if (we && in_range) begin
      data[word_idx[AW-1:0]] <= wdata;
    end
  end

  assign rdata = in_range ? data[word_idx[AW-1:0]] : '0;

endmodule

`default_nettype wire

// File: rtl/cpu_imem.sv
// ============================================================================
// Module  : cpu_imem
// Purpose : Instruction memory, DEPTH 32-bit words, combinational read by
//           word index. Indices beyond DEPTH read as 0x00000000 (a NOP).
//           The write port lets the array be filled in-system; the core
//           ties it off and programs are placed directly into data[].
// Ports   : clock            - write clock
//           we, waddr, wdata - word-indexed write port
//           raddr, rdata     - word-indexed combinational read port
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_imem
  import cpu_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic        clock,
  input  logic        we,
  input  logic [29:0] waddr,
  input  word_t       wdata,
  input  logic [29:0] raddr,
  output word_t       rdata
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  word_t data [0:DEPTH-1];

  logic r_in_range;
  logic w_in_range;

  assign r_in_range = (raddr < 30'(DEPTH));
  assign w_in_range = (waddr < 30'(DEPTH));

  always_ff @(posedge clock) begin
    if (we && w_in_range) begin
      data[waddr[AW-1:0]] <= wdata;
    end
  end

  assign rdata = r_in_range ? data[raddr[AW-1:0]] : '0;

endmodule

`default_nettype wire

// File: rtl/cpu_regfile.sv
// ============================================================================
// Module  : cpu_regfile
// Purpose : 32 x 32-bit register file, two combinational read ports and one
//           synchronous write port. Register 0 reads as zero and ignores
//           writes. Contents are never reset so preloaded values persist.
// Ports   : clock            - write clock
//           we, waddr, wdata - write port
//           raddr_a, rdata_a - read port A
//           raddr_b, rdata_b - read port B
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_regfile
  import cpu_pkg::*;
(
  input  logic       clock,
  input  logic       we,
  input  logic [4:0] waddr,
  input  word_t      wdata,
  input  logic [4:0] raddr_a,
  output word_t      rdata_a,
  input  logic [4:0] raddr_b,
  output word_t      rdata_b
);

  word_t data [0:31];

  always_ff @(posedge clock) begin
    if (we && (waddr != 5'd0)) begin
      data[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == 5'd0) ? '0 : data[raddr_a];
  assign rdata_b = (raddr_b == 5'd0) ? '0 : data[raddr_b];

endmodule

`default_nettype wire

// File: rtl/cpu.sv
// ============================================================================
// Module  : cpu
// Purpose : Single-cycle MIPS32 subset processor (add, sub, and, or, nor,
//           slt, addi, lw, sw, beq, optional j). One instruction is fetched,
//           executed and committed per clock. All architectural state is in
//           Registers_0.data, InstructionMemory_0.data and DataMemory_0.data.
//           Reset clears only the PC and suppresses every write on the edge
//           it is sampled.
// Ports   : clock - single clock, rising edge
//           reset - synchronous, active-high
// Config  : CPU_JUMP_EN - when defined, opcode 0x02 executes as j; otherwise
//           it is treated as an unknown opcode (NOP).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu
  import cpu_pkg::*;
#(
  parameter int INSTR_MEM_SIZE = 32,
  parameter int DATA_MEM_SIZE  = 64
) (
  input  logic clock,
  input  logic reset
);

  // --------------------------------------------------------------------------
  // Datapath signals
  // --------------------------------------------------------------------------
  word_t       pc;
  word_t       pc_plus4;
  word_t       pc_branch;
  word_t       pc_jump;
  word_t       pc_next;
  word_t       instr;

  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [5:0]  funct;
  logic [15:0] imm;
  word_t       imm_ext;

  word_t       rs_val;
  word_t       rt_val;
  word_t       alu_b;
  word_t       alu_y;
  logic        alu_zero;
  word_t       load_val;
  word_t       wb_val;
  logic [4:0]  wb_addr;

  // Control
  logic        reg_we;
  logic        mem_we;
  logic        use_imm;
  logic        mem_to_reg;
  logic        dst_is_rt;
  logic        is_branch;
  logic        is_jump;
  alu_op_e     alu_op;

  logic        unused_shamt;

  // --------------------------------------------------------------------------
  // Program counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      pc <= '0;
    end else begin
      pc <= pc_next;
    end
  end

  assign pc_plus4  = pc + word_t'(4);
  assign pc_branch = pc_plus4 + {imm_ext[29:0], 2'b00};
  assign pc_jump   = {pc_plus4[31:28], instr[25:0], 2'b00};

  always_comb begin
    pc_next = pc_plus4;
    if (is_jump) begin
      pc_next = pc_jump;
    end else if (is_branch && alu_zero) begin
      pc_next = pc_branch;
    end
  end

  // --------------------------------------------------------------------------
  // Instruction fetch
  // --------------------------------------------------------------------------
  cpu_imem #(
    .DEPTH (INSTR_MEM_SIZE)
  ) InstructionMemory_0 (
    .clock (clock),
    .we    (1'b0),
    .waddr ('0),
    .wdata ('0),
    .raddr (pc[31:2]),
    .rdata (instr)
  );

  assign opcode       = instr[31:26];
  assign rs           = instr[25:21];
  assign rt           = instr[20:16];
  assign rd           = instr[15:11];
  assign funct        = instr[5:0];
  assign imm          = instr[15:0];
  assign imm_ext      = sext16(imm);
  assign unused_shamt = ^instr[10:6];

  // --------------------------------------------------------------------------
  // Control decode. Anything not recognised leaves every enable low, which
  // makes it a NOP that simply advances the PC by 4.
  // --------------------------------------------------------------------------
  always_comb begin
    reg_we     = 1'b0;
    mem_we     = 1'b0;
    use_imm    = 1'b0;
    mem_to_reg = 1'b0;
    dst_is_rt  = 1'b0;
    is_branch  = 1'b0;
    is_jump    = 1'b0;
    alu_op     = ALU_ADD;

    case (opcode)
      OP_RTYPE: begin
        reg_we = 1'b1;
        case (funct)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_NOR:  alu_op = ALU_NOR;
          FN_SLT:  alu_op = ALU_SLT;
          default: reg_we = 1'b0;
        endcase
      end
      OP_ADDI: begin
        reg_we    = 1'b1;
        use_imm   = 1'b1;
        dst_is_rt = 1'b1;
      end
      OP_LW: begin
        reg_we     = 1'b1;
        use_imm    = 1'b1;
        dst_is_rt  = 1'b1;
        mem_to_reg = 1'b1;
      end
      OP_SW: begin
        mem_we  = 1'b1;
        use_imm = 1'b1;
      end
      OP_BEQ: begin
        // Equality is tested as rs - rt == 0 through the ALU zero flag.
        is_branch = 1'b1;
        alu_op    = ALU_SUB;
      end
`ifdef CPU_JUMP_EN
      OP_J: begin
        is_jump = 1'b1;
      end
`endif
      default: begin
        reg_we = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Register file, ALU, data memory
  // --------------------------------------------------------------------------
  assign wb_addr = dst_is_rt ? rt : rd;
  assign wb_val  = mem_to_reg ? load_val : alu_y;
  assign alu_b   = use_imm ? imm_ext : rt_val;

  // Writes are gated by reset so the instruction in flight at a reset edge
  // commits nothing.
  cpu_regfile Registers_0 (
    .clock   (clock),
    .we      (reg_we & ~reset),
    .waddr   (wb_addr),
    .wdata   (wb_val),
    .raddr_a (rs),
    .rdata_a (rs_val),
    .raddr_b (rt),
    .rdata_b (rt_val)
  );

  cpu_alu alu (
    .a      (rs_val),
    .b      (alu_b),
    .op     (alu_op),
    .result (alu_y),
    .zero   (alu_zero)
  );

  cpu_dmem #(
    .DEPTH (DATA_MEM_SIZE)
  ) DataMemory_0 (
    .clock (clock),
    .we    (mem_we & ~reset),
    .addr  (alu_y),
    .wdata (rt_val),
    .rdata (load_val)
  );

endmodule

`default_nettype wire

// File: tb/tb_cpu.sv
// ============================================================================
// Module  : tb_cpu
// Purpose : Self-checking bench for cpu: directed programs for each
//           instruction class plus randomized programs checked against an
//           instruction-level reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu;

  localparam int IM = 32;
  localparam int DM = 64;

  logic clock = 1'b0;
  logic reset = 1'b1;

  int checks = 0;
  int errors = 0;

  logic [31:0] prog_q [$];

  // Reference model state
  logic [31:0] m_regs [32];
  logic [31:0] m_dmem [DM];
  logic [31:0] m_imem [IM];
  logic [31:0] m_pc;

  cpu #(
    .INSTR_MEM_SIZE (IM),
    .DATA_MEM_SIZE  (DM)
  ) dut (
    .clock (clock),
    .reset (reset)
  );

  always #5 clock = ~clock;

  // --------------------------------------------------------------------------
  // Encoders and stimulus helpers
  // --------------------------------------------------------------------------
  function automatic logic [31:0] r_enc(input int rs, input int rt, input int rd, input int fn);
    return {6'h00, rs[4:0], rt[4:0], rd[4:0], 5'd0, fn[5:0]};
  endfunction

  function automatic logic [31:0] i_enc(input int op, input int rs, input int rt, input int imm);
    return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic put(input logic [31:0] w);
    prog_q.push_back(w);
  endtask

  // Holds reset, preloads $i = i, clears data memory, loads prog_q, then
  // releases reset after one edge.
  task automatic begin_prog();
    reset = 1'b1;
    for (int i = 0; i < 32; i++) dut.Registers_0.data[i] = i;
    for (int i = 0; i < DM; i++) dut.DataMemory_0.data[i] = '0;
    for (int i = 0; i < IM; i++)
      dut.InstructionMemory_0.data[i] = (i < prog_q.size()) ? prog_q[i] : 32'h0;
    tick();
    reset = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  // Reference model: one architectural instruction per call
  // --------------------------------------------------------------------------
  task automatic model_step();
    logic [31:0] ins, a, b, sx, ea, nxt, wval;
    logic [4:0]  widx;
    logic        wen;
    int          idx;
    idx  = int'(m_pc >> 2);
    ins  = (idx < IM) ? m_imem[idx] : 32'h0;
    a    = m_regs[ins[25:21]];
    b    = m_regs[ins[20:16]];
    sx   = {{16{ins[15]}}, ins[15:0]};
    nxt  = m_pc + 32'd4;
    wen  = 1'b0;
    widx = 5'd0;
    wval = 32'h0;
    case (ins[31:26])
      6'h00: begin
        widx = ins[15:11];
        wen  = 1'b1;
        case (ins[5:0])
          6'h20: wval = a + b;
          6'h22: wval = a - b;
          6'h24: wval = a & b;
          6'h25: wval = a | b;
          6'h27: wval = ~(a | b);
          6'h2A: wval = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: wen = 1'b0;
        endcase
      end
      6'h08: begin wen = 1'b1; widx = ins[20:16]; wval = a + sx; end
      6'h23: begin
        ea   = a + sx;
        idx  = int'(ea >> 2);
        wen  = 1'b1;
        widx = ins[20:16];
        wval = (idx < DM) ? m_dmem[idx] : 32'h0;
      end
      6'h2B: begin
        ea  = a + sx;
        idx = int'(ea >> 2);
        if (idx < DM) m_dmem[idx] = b;
      end
      6'h04: if (a == b) nxt = m_pc + 32'd4 + (sx << 2);
`ifdef CPU_JUMP_EN
      6'h02: nxt = {nxt[31:28], ins[25:0], 2'b00};
`endif
      default: ;
    endcase
    if (wen && widx != 5'd0) m_regs[widx] = wval;
    m_pc = nxt;
  endtask

  // --------------------------------------------------------------------------
  // Tests
  // --------------------------------------------------------------------------
  task automatic test_reset();
    prog_q.delete();
    put(r_enc(1, 2, 3, 'h20));
    begin_prog();
    checks++;
    if (dut.pc !== 32'd0) begin
      errors++; $display("FAIL reset_pc got %h want %h", dut.pc, 32'd0);
    end
    checks++;
    if (dut.Registers_0.data[3] !== 32'd3) begin
      errors++; $display("FAIL reset_keeps_regs got %h want %h", dut.Registers_0.data[3], 32'd3);
    end
  endtask

  task automatic test_rtype();
    prog_q.delete();
    put(r_enc(1, 2, 3, 'h20));    // add $3,$1,$2
    put(r_enc(10, 3, 4, 'h22));   // sub $4,$10,$3
    put(r_enc(3, 10, 5, 'h2A));   // slt $5,$3,$10
    put(r_enc(0, 0, 6, 'h27));    // nor $6,$0,$0
    put(r_enc(6, 1, 11, 'h2A));   // slt $11,$6,$1 (-1 < 1)
    put(r_enc(12, 13, 14, 'h24)); // and $14,$12,$13
    begin_prog();
    tick();
    checks++;
    if (dut.Registers_0.data[3] !== 32'd3) begin
      errors++; $display("FAIL add got %h want %h", dut.Registers_0.data[3], 32'd3);
    end
    checks++;
    if (dut.pc !== 32'd4) begin
      errors++; $display("FAIL add_pc got %h want %h", dut.pc, 32'd4);
    end
    tick();
    checks++;
    if (dut.Registers_0.data[4] !== 32'd7) begin
      errors++; $display("FAIL sub got %h want %h", dut.Registers_0.data[4], 32'd7);
    end
    tick();
    checks++;
    if (dut.Registers_0.data[5] !== 32'd1) begin
      errors++; $display("FAIL slt got %h want %h", dut.Registers_0.data[5], 32'd1);
    end
    tick();
    checks++;
    if (dut.Registers_0.data[6] !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL nor got %h want %h", dut.Registers_0.data[6], 32'hFFFF_FFFF);
    end
    tick();
    checks++;
    if (dut.Registers_0.data[11] !== 32'd1) begin
      errors++; $display("FAIL slt_signed got %h want %h", dut.Registers_0.data[11], 32'd1);
    end
    tick();
    checks++;
    if (dut.Registers_0.data[14] !== 32'd12) begin
      errors++; $display("FAIL and got %h want %h", dut.Registers_0.data[14], 32'd12);
    end
  endtask

  task automatic test_mem();
    int bad;
    prog_q.delete();
    put(i_enc('h2B, 0, 7, 8));      // sw $7,8($0)
    put(i_enc('h23, 0, 8, 8));      // lw $8,8($0)
    put(i_enc('h2B, 0, 7, 'h400));  // sw $7,0x400($0): out of range
    put(i_enc('h23, 0, 9, 'h400));  // lw $9,0x400($0): reads 0
    begin_prog();
    tick();
    checks++;
    if (dut.DataMemory_0.data[2] !== 32'd7) begin
      errors++; $display("FAIL sw got %h want %h", dut.DataMemory_0.data[2], 32'd7);
    end
    tick();
    checks++;
    if (dut.Registers_0.data[8] !== 32'd7) begin
      errors++; $display("FAIL lw got %h want %h", dut.Registers_0.data[8], 32'd7);
    end
    tick();
    bad = 0;
    for (int i = 0; i < DM; i++)
      if (dut.DataMemory_0.data[i] !== ((i == 2) ? 32'd7 : 32'd0)) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL sw_out_of_range changed_words got %0d want 0", bad);
    end
    tick();
    checks++;
    if (dut.Registers_0.data[9] !== 32'd0) begin
      errors++; $display("FAIL lw_out_of_range got %h want %h", dut.Registers_0.data[9], 32'd0);
    end
  endtask

  task automatic test_branch();
    prog_q.delete();
    put(i_enc('h04, 1, 1, 2));      // beq $1,$1,+2
    put(i_enc('h08, 0, 20, 99));    // skipped
    put(i_enc('h08, 0, 20, 99));    // skipped
    put(i_enc('h08, 0, 21, 55));    // addi $21,$0,55
    begin_prog();
    tick();
    checks++;
    if (dut.pc !== 32'd12) begin
      errors++; $display("FAIL beq_taken_pc got %h want %h", dut.pc, 32'd12);
    end
    tick();
    checks++;
    if (dut.Registers_0.data[21] !== 32'd55 || dut.Registers_0.data[20] !== 32'd20) begin
      errors++; $display("FAIL beq_target r21 %h r20 %h want %h %h",
                         dut.Registers_0.data[21], dut.Registers_0.data[20], 32'd55, 32'd20);
    end
    prog_q.delete();
    put(i_enc('h04, 1, 2, 2));      // beq $1,$2,+2 (not taken)
    begin_prog();
    tick();
    checks++;
    if (dut.pc !== 32'd4) begin
      errors++; $display("FAIL beq_fallthrough_pc got %h want %h", dut.pc, 32'd4);
    end
  endtask

  task automatic test_zero_reg();
    prog_q.delete();
    put(r_enc(1, 2, 0, 'h20));      // add $0,$1,$2
    put(r_enc(0, 0, 13, 'h20));     // add $13,$0,$0
    begin_prog();
    tick();
    checks++;
    if (dut.Registers_0.data[0] !== 32'd0) begin
      errors++; $display("FAIL r0_write got %h want %h", dut.Registers_0.data[0], 32'd0);
    end
    tick();
    checks++;
    if (dut.Registers_0.data[13] !== 32'd0) begin
      errors++; $display("FAIL r0_read got %h want %h", dut.Registers_0.data[13], 32'd0);
    end
  endtask

  task automatic test_reset_mid();
    prog_q.delete();
    put(i_enc('h08, 12, 12, 1));    // addi $12,$12,1
    put(i_enc('h2B, 0, 7, 8));      // sw $7,8($0)
    begin_prog();
    tick();
    checks++;
    if (dut.Registers_0.data[12] !== 32'd13 || dut.pc !== 32'd4) begin
      errors++; $display("FAIL mid_pre r12 %h pc %h want %h %h",
                         dut.Registers_0.data[12], dut.pc, 32'd13, 32'd4);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (dut.DataMemory_0.data[2] !== 32'd0) begin
      errors++; $display("FAIL mid_store_suppressed got %h want %h", dut.DataMemory_0.data[2], 32'd0);
    end
    checks++;
    if (dut.pc !== 32'd0) begin
      errors++; $display("FAIL mid_pc got %h want %h", dut.pc, 32'd0);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (dut.Registers_0.data[12] !== 32'd14 || dut.pc !== 32'd4) begin
      errors++; $display("FAIL mid_restart r12 %h pc %h want %h %h",
                         dut.Registers_0.data[12], dut.pc, 32'd14, 32'd4);
    end
  endtask

  task automatic test_jump();
    logic [31:0] want_pc;
    int bad;
`ifdef CPU_JUMP_EN
    want_pc = 32'd20;
`else
    want_pc = 32'd4;
`endif
    prog_q.delete();
    put({6'h02, 26'd5});            // j 5
    begin_prog();
    tick();
    checks++;
    if (dut.pc !== want_pc) begin
      errors++; $display("FAIL jump_pc got %h want %h", dut.pc, want_pc);
    end
    bad = 0;
    for (int i = 0; i < 32; i++) if (dut.Registers_0.data[i] !== 32'(i)) bad++;
    for (int i = 0; i < DM; i++) if (dut.DataMemory_0.data[i] !== 32'd0) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL jump_no_side_effect changed got %0d want 0", bad);
    end
  endtask

  task automatic test_random(input int cycles);
    logic [31:0] w;
    int rs, rt, op_sel;
    int fns [7] = '{'h20, 'h22, 'h24, 'h25, 'h27, 'h2A, 'h03};
    reset = 1'b1;
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = (i == 0) ? 32'h0 : 32'($urandom_range(0, 300));
      dut.Registers_0.data[i] = m_regs[i];
    end
    for (int i = 0; i < DM; i++) begin
      m_dmem[i] = $urandom;
      dut.DataMemory_0.data[i] = m_dmem[i];
    end
    for (int i = 0; i < IM; i++) begin
      rs = $urandom_range(0, 31);
      rt = $urandom_range(0, 31);
      op_sel = $urandom_range(0, 6);
      case (op_sel)
        0, 1: w = r_enc(rs, rt, $urandom_range(0, 31), fns[$urandom_range(0, 6)]);
        2: w = i_enc('h08, rs, rt, $urandom_range(0, 65535));
        3: w = i_enc('h23, ($urandom_range(0, 2) == 0) ? rs : 0, rt, $urandom_range(0, DM*4 + 32));
        4: w = i_enc('h2B, ($urandom_range(0, 2) == 0) ? rs : 0, rt, $urandom_range(0, DM*4 + 32));
        5: w = i_enc('h04, rs, ($urandom_range(0, 1) == 0) ? rs : rt, $urandom_range(0, 6) - 2);
        default: w = ($urandom_range(0, 1) == 0) ? {6'h02, 26'($urandom_range(0, IM + 4))}
                                                 : {6'h3F, 26'($urandom)};
      endcase
      m_imem[i] = w;
      dut.InstructionMemory_0.data[i] = w;
    end
    m_pc = 32'h0;
    tick();
    reset = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      tick();
      model_step();
      checks++;
      if (dut.pc !== m_pc) begin
        errors++; $display("FAIL rand_pc cycle %0d got %h want %h", c, dut.pc, m_pc);
      end
      for (int i = 0; i < 32; i++) begin
        checks++;
        if (((i == 0) ? 32'h0 : dut.Registers_0.data[i]) !== m_regs[i]) begin
          errors++; $display("FAIL rand_reg%0d cycle %0d got %h want %h", i, c, dut.Registers_0.data[i], m_regs[i]);
        end
      end
      for (int i = 0; i < DM; i++) begin
        checks++;
        if (dut.DataMemory_0.data[i] !== m_dmem[i]) begin
          errors++; $display("FAIL rand_mem%0d cycle %0d got %h want %h", i, c, dut.DataMemory_0.data[i], m_dmem[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_mem();
    test_branch();
    test_zero_reg();
    test_reset_mid();
    test_jump();
    for (int k = 0; k < 4; k++) test_random(50);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cpu.md
# cpu

Single-cycle MIPS32 subset processor and the top of the design: fetches one instruction per clock from an internal instruction memory, executes it, and commits the results on the same rising edge. Its only ports are clock and reset. All architectural state lives in three internal arrays under fixed hierarchical names. Testbenches preload programs and operands through those names and observe results the same way.

## Interface
- `INSTR_MEM_SIZE`, default 32: instruction memory depth in 32-bit words.
- `DATA_MEM_SIZE`, default 64: data memory depth in 32-bit words.
- `clock` input, 1 bit: single clock; all state updates on the rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- Hierarchical contract, treated as interface:
  - `Registers_0.data[0:31]`: 32×32-bit register file.
  - `InstructionMemory_0.data[0:INSTR_MEM_SIZE-1]`: 32-bit words.
  - `DataMemory_0.data[0:DATA_MEM_SIZE-1]`: 32-bit words.

## Operation
- Instruction fetch: 32-bit PC holds a byte address. The word index is PC[31:2]. An index ≥ INSTR_MEM_SIZE fetches 0x00000000, which executes as a NOP.
- R-type instructions (opcode 0x00): rd ← rs op rt. Supported funct codes:
  - add 0x20, sub 0x22, and 0x24, or 0x25, nor 0x27.
  - slt 0x2A: signed compare, result 1 or 0.
  - All arithmetic is 32-bit and wraps; no overflow traps.
  - Any other funct is a NOP.
- addi (opcode 0x08): rt ← rs + sign-extended imm16.
- lw (opcode 0x23): rt ← DataMemory[(rs + sext(imm)) >> 2].
- sw (opcode 0x2B): DataMemory[(rs + sext(imm)) >> 2] ← rt.
- Data address rules:
  - Address bits [1:0] are ignored.
  - Word index ≥ DATA_MEM_SIZE: a load returns 0 and a store is dropped.
- beq (opcode 0x04): if rs == rt, PC ← PC+4 + (sext(imm) << 2); otherwise PC ← PC+4. No delay slot.
- Unknown opcodes: NOP, PC ← PC+4.
- Register $0 always reads 0. Writes to it are discarded.
- Register file: two combinational read ports, one write port.
- Reset scope: reset clears only the PC. The register file and both memories are not touched, so preloaded contents survive reset.

## Timing
- Every instruction completes in one cycle (CPI = 1). PC, register write and memory write all commit on the same rising edge.
- A lw result is visible in the register file after the edge that ends its cycle. The next instruction reads the new value.
- While `reset`=1 at a rising edge:
  - PC ← 0.
  - No register or memory write occurs.
- The first instruction (word 0) executes in the first cycle with `reset`=0.
- Reset asserted mid-program: the instruction in flight at that edge commits nothing, and PC returns to 0.
- Reads are combinational from current state. Register and memory writes are visible to the following cycle.

## Configuration
- `CPU_JUMP_EN` defined: adds j (opcode 0x02), PC ← {PC+4[31:28], target26, 2'b00}.
- `CPU_JUMP_EN` undefined: opcode 0x02 is an unknown opcode (NOP, PC+4).

## Structure
- Shared package/header holds:
  - opcode constants (R-type, addi, lw, sw, beq, j);
  - funct constants;
  - ALU operation encodings;
  - word width (32).
- Required instances: `Registers_0` (register file), `InstructionMemory_0`, `DataMemory_0`, each exposing an array named `data`.
- One further natural sub-module: `alu` (32-bit add/sub/and/or/nor/slt with a zero flag used by beq).
- Control decode and PC logic stay in `cpu`.

## Test plan
- Common preload: registers $i = i. Every program starts with reset high for one edge, then low.
- add $3,$1,$2 at word 0 → after 1 cycle $3 = 3 and PC = 4.
- sub $4,$10,$3 → $4 = 7. slt $5,$3,$10 → $5 = 1.
- sw $7,8($0) → DataMemory.data[2] = 7. The following lw $8,8($0) → $8 = 7. sw to byte address 0x400 → no memory word changes.
- Equal operands, taken branch: beq $1,$1,+2 at word 0 → next fetch is word 3, skipped words leave no effect.
- Unequal operands, fall through: beq $1,$2,+2 → PC = 4.
- add $0,$1,$2 → $0 stays 0.
- Reset mid-run:
  - Assert reset during a sw → the store is suppressed, PC = 0.
  - After release, execution restarts at word 0 with registers intact.
- Jump: with `CPU_JUMP_EN`, j 5 → next PC = 20. Without it, the same word → PC = 4, no state change.
